// File: rtl/adc045_sched.sv
// Acquisition scheduler above the adc045 SPI front-end: periodic/software requests, sync generation, result capture.
// Optional per-channel 4-sample averaging is compiled in with `define ADC_SCHED_AVG_EN.
module adc045_sched #(
   parameter int PER_W       = 24,
   parameter int SYNC_HOLD   = 4,
   parameter int TIMEOUT_CYC = 1200000
) (
   input  logic             clk,
   input  logic             rst_l,
   input  logic             enable,
   input  logic [1:0]       mode,
   input  logic [13:0]      cfg,
   input  logic [PER_W-1:0] period,
   input  logic             sw_req,
   input  logic             err_clr,
   output logic             adc_sync,
   output logic [1:0]       adc_chsel,
   output logic [13:0]      adc_wreg,
   input  logic [23:0]      adc_data,
   input  logic             adc_channel,
   input  logic             adc_rd_en,
   output logic [23:0]      ch1_data,
   output logic [23:0]      ch2_data,
   output logic             data_valid,
   output logic             sched_busy,
   output logic             timeout_err,
   output logic [7:0]       overrun_cnt
);
   typedef enum logic [1:0] {IDLE, SYNC, WAIT_DATA, DONE} state_t;

   localparam int SC_W = $clog2(SYNC_HOLD + 1);
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

   state_t           state;
   logic [PER_W-1:0] per_cnt;
   logic             enable_d;
   logic             tick_pend;
   logic             sw_pend;
   logic [SC_W-1:0]  sync_cnt;
   logic [TO_W-1:0]  to_cnt;
   logic [1:0]       word_cnt;
   logic             tick;
   logic             serve_tick;
   logic             serve_sw;
   logic [1:0]       need;
   logic             last_word;
   logic             dv_ok;

   assign tick       = enable && (period != '0) && (per_cnt == period - PER_W'(1));
   assign serve_tick = (state == IDLE) && enable && tick_pend;
   assign serve_sw   = (state == IDLE) && enable && !tick_pend && sw_pend;
   assign need       = (adc_chsel == 2'd1 || adc_chsel == 2'd2) ? 2'd1 : 2'd2;
   assign last_word  = adc_rd_en && (word_cnt + 2'd1 == need);
   assign sched_busy = (state != IDLE);

`ifdef ADC_SCHED_AVG_EN
   logic [25:0] acc_reg [2];
   logic [1:0]  scnt_reg [2];
   logic [1:0]  upd_reg;
   logic [1:0]  exp_mask;
   logic [1:0]  cur_upd;
   logic [25:0] sum;

   assign sum      = acc_reg[adc_channel] + {2'b00, adc_data};
   assign exp_mask = (adc_chsel == 2'd1) ? 2'b01 : (adc_chsel == 2'd2) ? 2'b10 : 2'b11;
   assign cur_upd  = (scnt_reg[adc_channel] == 2'd3) ? (adc_channel ? 2'b10 : 2'b01) : 2'b00;
   // Only report completion once every channel of this mode produced a fresh average
   assign dv_ok    = (((upd_reg | cur_upd) & exp_mask) == exp_mask);
`else
   assign dv_ok    = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state       <= IDLE;
         per_cnt     <= '0;
         enable_d    <= 1'b0;
         tick_pend   <= 1'b0;
         sw_pend     <= 1'b0;
         sync_cnt    <= '0;
         to_cnt      <= '0;
         word_cnt    <= 2'd0;
         adc_sync    <= 1'b0;
         adc_chsel   <= 2'd0;
         adc_wreg    <= 14'd0;
         ch1_data    <= 24'd0;
         ch2_data    <= 24'd0;
         data_valid  <= 1'b0;
         timeout_err <= 1'b0;
         overrun_cnt <= 8'd0;
`ifdef ADC_SCHED_AVG_EN
         acc_reg[0]  <= '0;
         acc_reg[1]  <= '0;
         scnt_reg[0] <= '0;
         scnt_reg[1] <= '0;
         upd_reg     <= '0;
`endif
      end else begin
         enable_d   <= enable;
         data_valid <= 1'b0;
         // adc045 only re-reads channel selection cleanly from a fresh enable
         if (enable && !enable_d) begin
            adc_chsel <= mode;
            adc_wreg  <= cfg;
`ifdef ADC_SCHED_AVG_EN
            acc_reg[0]  <= '0;
            acc_reg[1]  <= '0;
            scnt_reg[0] <= '0;
            scnt_reg[1] <= '0;
`endif
         end

         if (!enable || period == '0 || tick) per_cnt <= '0;
         else                                 per_cnt <= per_cnt + PER_W'(1);

         if (err_clr) timeout_err <= 1'b0;

         case (state)
            IDLE: begin
               if (serve_tick || serve_sw) begin
                  state    <= SYNC;
                  adc_sync <= 1'b1;
                  sync_cnt <= '0;
`ifdef ADC_SCHED_AVG_EN
                  upd_reg  <= '0;
`endif
               end
            end
            SYNC: begin
               if (sync_cnt == SC_W'(SYNC_HOLD - 1)) begin
                  adc_sync <= 1'b0;
                  state    <= WAIT_DATA;
                  word_cnt <= 2'd0;
                  to_cnt   <= '0;
               end else begin
                  sync_cnt <= sync_cnt + SC_W'(1);
               end
            end
            WAIT_DATA: begin
               to_cnt <= to_cnt + TO_W'(1);
               if (adc_rd_en) begin
                  word_cnt <= word_cnt + 2'd1;
`ifdef ADC_SCHED_AVG_EN
                  if (scnt_reg[adc_channel] == 2'd3) begin
                     if (adc_channel) ch2_data <= sum[25:2];
                     else             ch1_data <= sum[25:2];
                     acc_reg[adc_channel]  <= '0;
                     scnt_reg[adc_channel] <= 2'd0;
                     upd_reg <= upd_reg | cur_upd;
                  end else begin
                     acc_reg[adc_channel]  <= sum;
                     scnt_reg[adc_channel] <= scnt_reg[adc_channel] + 2'd1;
                  end
`else
                  if (adc_channel) ch2_data <= adc_data;
                  else             ch1_data <= adc_data;
`endif
               end
               if (last_word) begin
                  state      <= DONE;
                  data_valid <= dv_ok;
               end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
                  timeout_err <= 1'b1;
                  state       <= IDLE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase

         if (!enable) begin
            tick_pend <= 1'b0;
            sw_pend   <= 1'b0;
         end else begin
            // A tick that cannot be queued is dropped and counted
            if (serve_tick)
               tick_pend <= 1'b0;
            else if (tick && state == IDLE && !tick_pend)
               tick_pend <= 1'b1;
            if (tick && (tick_pend || state != IDLE) && overrun_cnt != 8'hFF)
               overrun_cnt <= overrun_cnt + 8'd1;
            if (sw_req)        sw_pend <= 1'b1;
            else if (serve_sw) sw_pend <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_adc045_sched.sv
// Self-checking bench for adc045_sched: ADC responder, request-level reference model, per-cycle compare.
`timescale 1ns/1ps
module tb_adc045_sched;
   localparam int PER_W     = 24;
   localparam int SYNC_HOLD = 4;
   localparam int TO_CYC    = 300;

   logic             clk = 1'b0;
   logic             rst_l = 1'b0;
   logic             enable = 1'b0;
   logic [1:0]       mode = 2'd0;
   logic [13:0]      cfg = 14'd0;
   logic [PER_W-1:0] period = '0;
   logic             sw_req = 1'b0;
   logic             err_clr = 1'b0;
   logic [23:0]      adc_data = 24'd0;
   logic             adc_channel = 1'b0;
   logic             adc_rd_en = 1'b0;
   logic             adc_sync;
   logic [1:0]       adc_chsel;
   logic [13:0]      adc_wreg;
   logic [23:0]      ch1_data;
   logic [23:0]      ch2_data;
   logic             data_valid;
   logic             sched_busy;
   logic             timeout_err;
   logic [7:0]       overrun_cnt;

   adc045_sched #(.PER_W(PER_W), .SYNC_HOLD(SYNC_HOLD), .TIMEOUT_CYC(TO_CYC)) dut (
      .clk(clk), .rst_l(rst_l), .enable(enable), .mode(mode), .cfg(cfg), .period(period),
      .sw_req(sw_req), .err_clr(err_clr), .adc_sync(adc_sync), .adc_chsel(adc_chsel),
      .adc_wreg(adc_wreg), .adc_data(adc_data), .adc_channel(adc_channel), .adc_rd_en(adc_rd_en),
      .ch1_data(ch1_data), .ch2_data(ch2_data), .data_valid(data_valid), .sched_busy(sched_busy),
      .timeout_err(timeout_err), .overrun_cnt(overrun_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int dv_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ADC responder controls
   bit          respond = 1'b1;
   bit          rnd_data = 1'b0;
   bit          spurious = 1'b0;
   int          resp_delay = 0;
   logic [23:0] val0 = 24'd0;
   logic [23:0] val1 = 24'd0;

   initial begin
      int   cd;
      int   left;
      logic prev_sync;
      cd = 0; left = 0; prev_sync = 1'b0;
      forever begin
         @(negedge clk);
         adc_rd_en = 1'b0;
         if (!rst_l) left = 0;
         if (prev_sync && !adc_sync && respond) begin
            cd   = resp_delay;
            left = (adc_chsel == 2'd1 || adc_chsel == 2'd2) ? 1 : 2;
         end
         prev_sync = adc_sync;
         if (left > 0) begin
            if (cd > 0) cd--;
            else begin
               adc_rd_en   = 1'b1;
               adc_channel = (left == 2 || adc_chsel == 2'd1) ? 1'b0 : 1'b1;
               adc_data    = rnd_data ? 24'($urandom) : (adc_channel ? val1 : val0);
               left--;
            end
         end else if (spurious && !sched_busy && $urandom_range(7) == 0) begin
            adc_rd_en   = 1'b1;
            adc_channel = 1'($urandom_range(1));
            adc_data    = 24'($urandom);
         end
      end
   end

   // Reference model: phase 0 idle, 1 sync, 2 waiting for words, 3 done
   int          m_phase, m_sync_left, m_words, m_age, m_ovr;
   longint      m_pcnt;
   bit          m_tp, m_sp, m_en_prev, m_terr;
   logic [1:0]  m_chsel;
   logic [13:0] m_wreg;
   logic [23:0] m_ch1, m_ch2;

   initial begin
      int old_phase, need;
      bit old_tp, tick, tmo;
      forever begin
         @(posedge clk or negedge rst_l);
         if (!rst_l) begin
            m_phase = 0; m_sync_left = 0; m_words = 0; m_age = 0; m_ovr = 0; m_pcnt = 0;
            m_tp = 0; m_sp = 0; m_en_prev = 0; m_terr = 0;
            m_chsel = 2'd0; m_wreg = 14'd0; m_ch1 = 24'd0; m_ch2 = 24'd0;
         end else begin
            old_phase = m_phase;
            old_tp    = m_tp;
            tmo       = 1'b0;
            tick      = enable && period != 0 && (m_pcnt == longint'(period) - 1);
            m_pcnt    = (!enable || period == 0 || tick) ? 0 : m_pcnt + 1;
            case (old_phase)
               0: if (enable && (m_tp || m_sp)) begin
                     if (m_tp) m_tp = 1'b0; else m_sp = 1'b0;
                     m_phase = 1; m_sync_left = SYNC_HOLD;
                  end
               1: begin
                     m_sync_left--;
                     if (m_sync_left == 0) begin m_phase = 2; m_words = 0; m_age = 0; end
                  end
               2: begin
                     need = (m_chsel == 2'd1 || m_chsel == 2'd2) ? 1 : 2;
                     if (adc_rd_en) begin
                        if (adc_channel) m_ch2 = adc_data; else m_ch1 = adc_data;
                        m_words++;
                     end
                     if (adc_rd_en && m_words == need) m_phase = 3;
                     else if (m_age == TO_CYC - 1) begin m_phase = 0; tmo = 1'b1; end
                     m_age++;
                  end
               default: m_phase = 0;
            endcase
            if (!enable) begin
               m_tp = 1'b0; m_sp = 1'b0;
            end else begin
               if (tick) begin
                  if (old_tp || old_phase != 0) begin
                     if (m_ovr < 255) m_ovr++;
                  end else m_tp = 1'b1;
               end
               if (sw_req) m_sp = 1'b1;
            end
            if (tmo) m_terr = 1'b1;
            else if (err_clr) m_terr = 1'b0;
            if (enable && !m_en_prev) begin m_chsel = mode; m_wreg = cfg; end
            m_en_prev = enable;
         end
      end
   end

   // Per-cycle compare of every output against the model
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rst_l) begin
            chk("adc_sync",    32'(adc_sync),    32'(m_phase == 1));
            chk("adc_chsel",   32'(adc_chsel),   32'(m_chsel));
            chk("adc_wreg",    32'(adc_wreg),    32'(m_wreg));
            chk("ch1_data",    32'(ch1_data),    32'(m_ch1));
            chk("ch2_data",    32'(ch2_data),    32'(m_ch2));
            chk("data_valid",  32'(data_valid),  32'(m_phase == 3));
            chk("sched_busy",  32'(sched_busy),  32'(m_phase != 0));
            chk("timeout_err", 32'(timeout_err), 32'(m_terr));
            chk("overrun_cnt", 32'(overrun_cnt), 32'(m_ovr));
            if (data_valid === 1'b1) dv_seen++;
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_sw();
      sw_req = 1'b1; cyc(1); sw_req = 1'b0;
   endtask

   task automatic do_reset();
      enable = 1'b0; sw_req = 1'b0; err_clr = 1'b0; period = '0;
      @(negedge clk);
      rst_l = 1'b0;
      #1;
      chk("rst adc_sync",    32'(adc_sync),    32'd0);
      chk("rst adc_chsel",   32'(adc_chsel),   32'd0);
      chk("rst adc_wreg",    32'(adc_wreg),    32'd0);
      chk("rst ch1_data",    32'(ch1_data),    32'd0);
      chk("rst ch2_data",    32'(ch2_data),    32'd0);
      chk("rst data_valid",  32'(data_valid),  32'd0);
      chk("rst sched_busy",  32'(sched_busy),  32'd0);
      chk("rst timeout_err", 32'(timeout_err), 32'd0);
      chk("rst overrun_cnt", 32'(overrun_cnt), 32'd0);
      cyc(3);
      rst_l = 1'b1;
      $display("reset released at %0t", $time);
   endtask

   initial begin
      int dv0;
      do_reset();

      // Periodic dual-channel acquisitions
      mode = 2'd0; cfg = 14'h1A5; period = 24'd1000;
      respond = 1'b1; resp_delay = 5; rnd_data = 1'b0; spurious = 1'b0;
      val0 = 24'h123456; val1 = 24'hABCDEF;
      dv0 = dv_seen;
      enable = 1'b1;
      cyc(2100);
      chk("t1 ch1_data", 32'(ch1_data), 32'h123456);
      chk("t1 ch2_data", 32'(ch2_data), 32'hABCDEF);
      chk("t1 adc_wreg", 32'(adc_wreg), 32'h1A5);
      chk("t1 dv count", 32'(dv_seen - dv0), 32'd2);
      chk("t1 overrun",  32'(overrun_cnt), 32'd0);
      $display("t1 periodic dual: ch1=%h ch2=%h", ch1_data, ch2_data);

      // Single-channel software request
      do_reset();
      mode = 2'd1; period = '0; val0 = 24'h00FF00;
      enable = 1'b1;
      cyc(2);
      dv0 = dv_seen;
      pulse_sw();
      cyc(50);
      chk("t2 ch1_data",  32'(ch1_data),  32'h00FF00);
      chk("t2 ch2_data",  32'(ch2_data),  32'h0);
      chk("t2 adc_chsel", 32'(adc_chsel), 32'd1);
      chk("t2 dv count",  32'(dv_seen - dv0), 32'd1);
      $display("t2 sw single: ch1=%h ch2=%h", ch1_data, ch2_data);

      // Tick and sw_req in the same cycle
      enable = 1'b0; cyc(3);
      mode = 2'd0; period = 24'd20; val0 = 24'h000111; val1 = 24'h000222;
      dv0 = dv_seen;
      enable = 1'b1;
      cyc(19);
      pulse_sw();
      period = '0;
      cyc(60);
      chk("t3 dv count", 32'(dv_seen - dv0), 32'd2);
      chk("t3 overrun",  32'(overrun_cnt), 32'd0);
      $display("t3 tick+sw: acquisitions=%0d overrun=%0d", dv_seen - dv0, overrun_cnt);

      // Timeout then clear
      enable = 1'b0; cyc(3);
      respond = 1'b0;
      enable = 1'b1;
      cyc(1);
      dv0 = dv_seen;
      pulse_sw();
      cyc(TO_CYC + 20);
      chk("t4 timeout_err", 32'(timeout_err), 32'd1);
      chk("t4 sched_busy",  32'(sched_busy),  32'd0);
      chk("t4 dv count",    32'(dv_seen - dv0), 32'd0);
      err_clr = 1'b1; cyc(1); err_clr = 1'b0;
      chk("t4 err_clr", 32'(timeout_err), 32'd0);
      $display("t4 timeout: cleared=%0d", !timeout_err);

      // Randomized rounds
      rnd_data = 1'b1; spurious = 1'b1;
      for (int r = 0; r < 40; r++) begin
         enable     = ($urandom_range(9) != 0);
         mode       = 2'($urandom_range(3));
         cfg        = 14'($urandom);
         period     = ($urandom_range(3) == 0) ? '0 : PER_W'($urandom_range(400, 20));
         resp_delay = $urandom_range(40);
         respond    = ($urandom_range(9) != 0);
         for (int c = 0; c < 400; c++) begin
            sw_req  = ($urandom_range(19) == 0);
            err_clr = ($urandom_range(49) == 0);
            cyc(1);
         end
         sw_req = 1'b0; err_clr = 1'b0;
         $display("rand round %0d: en=%0d mode=%0d period=%0d dv=%0d ovr=%0d", r, enable, mode, period, dv_seen, overrun_cnt);
      end

      // Overrun saturation with slow ADC responses
      do_reset();
      mode = 2'd0; period = 24'd50; resp_delay = 200; respond = 1'b1; spurious = 1'b0;
      enable = 1'b1;
      cyc(30000);
      chk("t6 overrun sat", 32'(overrun_cnt), 32'd255);
      $display("t6 overrun: cnt=%0d", overrun_cnt);

      enable = 1'b0;
      cyc(5);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
